// File: rtl/water_level_pkg.sv
// water_level_pkg: channel state encodings, fault codes and probe-vector validity check
package water_level_pkg;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FILLING = 3'd1;
  localparam logic [2:0] S_FULL    = 3'd2;
  localparam logic [2:0] S_FAULT   = 3'd3;
  localparam logic [1:0] F_NONE    = 2'b00;
  localparam logic [1:0] F_INVALID = 2'b01;
  localparam logic [1:0] F_TIMEOUT = 2'b10;
  // A thermometer code plus one carries into exactly one fresh bit, so it shares no set bit with itself.
  function automatic logic is_thermometer(input logic [31:0] vec);
    return (vec & (vec + 32'd1)) == 32'd0;
  endfunction
endpackage

// File: rtl/tank_channel_fsm.sv
// tank_channel_fsm: one tank's pump FSM with refill hysteresis, min off time, fill timeout, latched faults
//   in : clk, reset, level (probe vector), enable, fault_clr
//   out: motor_on, fault, fault_code, state_o
module tank_channel_fsm
  import water_level_pkg::*;
#(
  parameter int N_LEVELS     = 3,
  parameter int REFILL_IDX   = 1,
  parameter int MIN_OFF_CYC  = 8,
  parameter int FILL_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_LEVELS-1:0] level,
  input  logic                enable,
  input  logic                fault_clr,
  output logic                motor_on,
  output logic                fault,
  output logic [1:0]          fault_code,
  output logic [2:0]          state_o
);
  localparam int FW = $clog2(FILL_TIMEOUT);
  localparam int OW = $clog2(MIN_OFF_CYC + 1) > 0 ? $clog2(MIN_OFF_CYC + 1) : 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(FILL_TIMEOUT - 1);
  localparam logic [OW-1:0] OFF_MAX  = OW'(MIN_OFF_CYC);
  logic [2:0]    state;
  logic [1:0]    code;
  logic [FW-1:0] fill_cnt;
  logic [OW-1:0] off_cnt;
  logic          valid, top;
  always_comb begin
    valid = is_thermometer(32'(level));
    top   = level[N_LEVELS-1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      code     <= F_NONE;
      fill_cnt <= '0;
      off_cnt  <= '0;
    end else if (state == S_FAULT) begin
      // A fault survives enable=0; only a clear with a sane probe vector releases it.
      if (fault_clr && valid) begin
        state <= S_IDLE;
        code  <= F_NONE;
      end
    end else if (!enable) begin
      state <= S_IDLE;
    end else if (!valid) begin
      state <= S_FAULT;
      code  <= F_INVALID;
    end else begin
      case (state)
        S_IDLE, S_FILLING: begin
          if (top) begin
            state   <= S_FULL;
            off_cnt <= '0;
          end else if (state == S_IDLE) begin
            state    <= S_FILLING;
            fill_cnt <= '0;
          end else if (fill_cnt == FILL_MAX) begin
            state <= S_FAULT;
            code  <= F_TIMEOUT;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        S_FULL: begin
          // Restart only once the refill probe clears and the pump has rested long enough.
          if (off_cnt != OFF_MAX) off_cnt <= off_cnt + 1'b1;
          if (!level[REFILL_IDX] && off_cnt == OFF_MAX) begin
            state    <= S_FILLING;
            fill_cnt <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  always_comb begin
    motor_on   = state == S_FILLING;
    fault      = state == S_FAULT;
    fault_code = code;
    state_o    = state;
  end
endmodule

// File: rtl/multi_tank_level_controller.sv
// multi_tank_level_controller: NUM_TANKS independent pump controllers with a combined fault flag
//   in : clk, reset, level (N_LEVELS per tank), enable, fault_clr (per tank)
//   out: motor_on, fault, fault_code (2b/tank), state_o (3b/tank), any_fault
module multi_tank_level_controller
  import water_level_pkg::*;
#(
  parameter int NUM_TANKS    = 4,
  parameter int N_LEVELS     = 3,
  parameter int REFILL_IDX   = 1,
  parameter int MIN_OFF_CYC  = 8,
  parameter int FILL_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_TANKS*N_LEVELS-1:0] level,
  input  logic [NUM_TANKS-1:0]          enable,
  input  logic [NUM_TANKS-1:0]          fault_clr,
  output logic [NUM_TANKS-1:0]          motor_on,
  output logic [NUM_TANKS-1:0]          fault,
  output logic [2*NUM_TANKS-1:0]        fault_code,
  output logic [3*NUM_TANKS-1:0]        state_o,
  output logic                          any_fault
);
  for (genvar i = 0; i < NUM_TANKS; i++) begin : g_tank
    tank_channel_fsm #(
      .N_LEVELS    (N_LEVELS),
      .REFILL_IDX  (REFILL_IDX),
      .MIN_OFF_CYC (MIN_OFF_CYC),
      .FILL_TIMEOUT(FILL_TIMEOUT)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .level     (level[i*N_LEVELS +: N_LEVELS]),
      .enable    (enable[i]),
      .fault_clr (fault_clr[i]),
      .motor_on  (motor_on[i]),
      .fault     (fault[i]),
      .fault_code(fault_code[2*i +: 2]),
      .state_o   (state_o[3*i +: 3])
    );
  end
  always_comb any_fault = |fault;
endmodule
